// File: rtl/hvsync_recover_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hvsync_recover_pkg
// Description : Shared CRT sync timing constants, recovery state encoding and
//               a saturating-increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hvsync_recover_pkg;

    localparam int c_H_DISPLAY    = 256;
    localparam int c_H_MAX        = 308;
    localparam int c_H_SYNC_START = 264;
    localparam int c_V_DISPLAY    = 240;
    localparam int c_V_MAX        = 261;
    localparam int c_V_SYNC_START = 254;

    // The generator registers its sync outputs and the recoverer detects the
    // rise one cycle later, hence the two-cycle offset on the horizontal edge.
    localparam int c_H_EDGE_POS   = c_H_SYNC_START + 2;
    localparam int c_V_EDGE_POS   = c_V_SYNC_START;

    localparam int c_LOCK_LINES   = 4;
    localparam int c_MISS_LIMIT   = 2;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } sync_state_t;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hvsync_recover_sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_detect
// Description : 1-bit rising-edge detector; the history register preloads
//               high in reset so a level held through reset gives no edge.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= 1'b1;
        end else begin
            r_q <= din;
        end
    end

    assign rise = din & ~r_q;

endmodule
`default_nettype wire

// File: rtl/hvsync_recover.sv
`default_nettype none
// ============================================================================
// Module      : hvsync_recover
// Description : Recovers beam position, display enable, line/frame lengths and
//               lock status from an incoming hsync/vsync pair.
// Revision    : 1.0 - initial release
// ============================================================================
module hvsync_recover
    import hvsync_recover_pkg::*;
#(
    parameter int H_DISPLAY  = c_H_DISPLAY,
    parameter int H_MAX      = c_H_MAX,
    parameter int H_EDGE_POS = c_H_EDGE_POS,
    parameter int V_DISPLAY  = c_V_DISPLAY,
    parameter int V_MAX      = c_V_MAX,
    parameter int V_EDGE_POS = c_V_EDGE_POS,
    parameter int LOCK_LINES = c_LOCK_LINES,
    parameter int MISS_LIMIT = c_MISS_LIMIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [8:0] hpos,
    output logic [8:0] vpos,
    output logic       display_on,
    output logic       locked,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines
);

    localparam logic [8:0] c_HMAX   = 9'(H_MAX);
    localparam logic [8:0] c_HEDGE  = 9'(H_EDGE_POS);
    localparam logic [8:0] c_HPRE   = 9'(H_EDGE_POS - 1);
    localparam logic [8:0] c_HDISP  = 9'(H_DISPLAY);
    localparam logic [8:0] c_VMAX   = 9'(V_MAX);
    localparam logic [8:0] c_VEDGE  = 9'(V_EDGE_POS);
    localparam logic [8:0] c_VDISP  = 9'(V_DISPLAY);
    localparam int         c_HCNT_W = $clog2(LOCK_LINES + 1);
    localparam int         c_MCNT_W = $clog2(MISS_LIMIT + 1);
    localparam logic [c_HCNT_W-1:0] c_HCNT_FULL = c_HCNT_W'(LOCK_LINES);
    localparam logic [c_MCNT_W-1:0] c_MCNT_LAST = c_MCNT_W'(MISS_LIMIT - 1);

    logic [8:0]          r_hpos;
    logic [8:0]          r_vpos;
    logic [9:0]          r_lc;
    logic [9:0]          r_fc;
    logic [9:0]          r_line_len;
    logic [9:0]          r_frame_lines;
    logic                r_locked;
    sync_state_t         r_state;
    logic [c_HCNT_W-1:0] r_hcnt;
    logic [c_MCNT_W-1:0] r_mcnt;
    logic                r_vok;

    logic w_hrise;
    logic w_vrise;
    logic w_h_at_max;
    logic w_hmatch;
    logic w_vmatch;
    logic w_hmiss;

    sync_edge_detect u_hedge (
        .clk   (clk),
        .reset (reset),
        .din   (hsync_in),
        .rise  (w_hrise)
    );

    sync_edge_detect u_vedge (
        .clk   (clk),
        .reset (reset),
        .din   (vsync_in),
        .rise  (w_vrise)
    );

    assign w_h_at_max = (r_hpos == c_HMAX);
    assign w_hmatch   = w_hrise && (r_hpos == c_HPRE);
    assign w_vmatch   = w_vrise && (r_vpos == c_VEDGE);
    // A missing edge at the expected slot and an edge anywhere else both count.
    assign w_hmiss    = ((r_hpos == c_HPRE) && !w_hrise) || (w_hrise && !w_hmatch);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_lc          <= '0;
            r_fc          <= '0;
            r_line_len    <= '0;
            r_frame_lines <= '0;
        end else begin
            if (w_hrise) begin
                r_hpos <= c_HEDGE;
            end else if (w_h_at_max) begin
                r_hpos <= '0;
            end else begin
                r_hpos <= r_hpos + 9'd1;
            end

            if (w_vrise) begin
                r_vpos <= c_VEDGE;
            end else if (w_h_at_max && !w_hrise) begin
                r_vpos <= (r_vpos == c_VMAX) ? 9'd0 : r_vpos + 9'd1;
            end

            if (w_hrise) begin
                r_lc       <= '0;
                r_line_len <= sat_inc10(r_lc);
            end else begin
                r_lc       <= sat_inc10(r_lc);
            end

            // An hsync coinciding with vsync is the first line of the new frame.
            if (w_vrise) begin
                r_frame_lines <= r_fc;
                r_fc          <= w_hrise ? 10'd1 : 10'd0;
            end else if (w_hrise) begin
                r_fc          <= sat_inc10(r_fc);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= SEARCH;
            r_locked <= 1'b0;
            r_hcnt   <= '0;
            r_mcnt   <= '0;
            r_vok    <= 1'b0;
        end else begin
            case (r_state)
                SEARCH: begin
                    if (w_hmatch) begin
                        if (r_hcnt != c_HCNT_FULL) begin
                            r_hcnt <= r_hcnt + 1'b1;
                        end
                    end else if (w_hrise) begin
                        r_hcnt <= '0;
                    end

                    if (w_vmatch) begin
                        r_vok <= 1'b1;
                    end else if (w_vrise) begin
                        r_vok <= 1'b0;
                    end

                    if ((r_hcnt == c_HCNT_FULL) && r_vok) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                        r_mcnt   <= '0;
                    end
                end
                LOCKED: begin
                    if ((w_vrise && !w_vmatch) || (w_hmiss && (r_mcnt == c_MCNT_LAST))) begin
                        r_state  <= SEARCH;
                        r_locked <= 1'b0;
                        r_hcnt   <= '0;
                        r_vok    <= 1'b0;
                        r_mcnt   <= '0;
                    end else if (w_hmatch) begin
                        r_mcnt <= '0;
                    end else if (w_hmiss) begin
                        r_mcnt <= r_mcnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign locked      = r_locked;
    assign line_len    = r_line_len;
    assign frame_lines = r_frame_lines;
    assign display_on  = r_locked && (r_hpos < c_HDISP) && (r_vpos < c_VDISP);

endmodule
`default_nettype wire

// File: doc/hvsync_recover.md
Name: hvsync_recover

Overview:
- Sits at the receive end of the simulated-CRT sync interface.
- Samples incoming hsync/vsync and regenerates beam position (hpos, vpos) and display_on, aligned cycle-for-cycle with the source's counters once locked.
- Also measures line length and lines per frame, and reports lock status.
- Used by capture/overlay logic that must track a video stream it did not generate.

Parameters:
- H_DISPLAY, 256, visible width
- H_MAX, 308, last hpos value of a line (line period H_MAX+1)
- H_EDGE_POS, 266, hpos value loaded at the edge following the cycle in which a hsync rise is detected
- V_DISPLAY, 240, visible height
- V_MAX, 261, last vpos value of a frame
- V_EDGE_POS, 254, vpos value loaded at the edge following the cycle in which a vsync rise is detected
- LOCK_LINES, 4, consecutive matching hsync edges required for lock
- MISS_LIMIT, 2, consecutive missed/mismatched hsync edges that drop lock

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- hsync_in  in  1  incoming horizontal sync, active-high, clk-synchronous
- vsync_in  in  1  incoming vertical sync, active-high, clk-synchronous
- hpos  out  9  recovered horizontal position (registered)
- vpos  out  9  recovered vertical position (registered)
- display_on  out  1  locked && hpos<H_DISPLAY && vpos<V_DISPLAY (combinational)
- locked  out  1  timing lock achieved (registered)
- line_len  out  10  clocks between the last two hsync rises (registered, saturating at 1023)
- frame_lines  out  10  hsync rises between the last two vsync rises (registered, saturating at 1023)

Behaviour:
- Reset (synchronous, active-high):
  - hpos=0, vpos=0, locked=0, line_len=0, frame_lines=0.
  - State=SEARCH; all internal counters cleared.
  - hsync_q and vsync_q load 1, so an input held high through reset release produces no edge.
  - Reset mid-operation returns to exactly this state on the next edge.
- Edge detection: hrise = hsync_in & ~hsync_q, vrise = vsync_in & ~vsync_q. hsync_q and vsync_q register their inputs every cycle.
- Horizontal counter, priority order:
  - hrise: hpos <= H_EDGE_POS.
  - else hpos==H_MAX: hpos <= 0.
  - else hpos <= hpos+1.
- Vertical counter, priority order:
  - vrise: vpos <= V_EDGE_POS.
  - else hpos==H_MAX and no hrise: vpos <= (vpos==V_MAX) ? 0 : vpos+1.
  - else hold.
- Match rules:
  - hsync match: hrise with hpos==H_EDGE_POS-1.
  - vsync match: vrise with vpos==V_EDGE_POS.
  - hsync miss: in LOCKED, hpos==H_EDGE_POS-1 with no hrise; also any hrise that is not a match.
- Measurement:
  - Cycle counter lc (10-bit, saturating at 1023) cleared on hrise; line_len <= lc+1 (saturating) on hrise.
  - Line counter fc counts hrises, cleared on vrise; frame_lines <= fc on vrise.
- State machine:
  - SEARCH:
    - Match increments hcnt (saturating at LOCK_LINES); a non-matching hrise clears hcnt.
    - A vsync match sets vok; a non-matching vrise clears vok.
    - Enter LOCKED when hcnt==LOCK_LINES and vok; locked=1 from the following cycle.
  - LOCKED:
    - Each miss increments mcnt; a match clears mcnt.
    - mcnt reaching MISS_LIMIT causes SEARCH; a non-matching vrise causes SEARCH immediately.
    - On entry to SEARCH: locked=0, hcnt=0, vok=0, mcnt=0.
- Simultaneous hrise and vrise: both apply in the same cycle.
- Latency: with default parameters driven by the team's hvsync_generator, recovered hpos/vpos equal the generator's hpos/vpos every cycle after the first matching edges.

Decomposition:
- Shared package (e.g. video_timing_pkg) holds the sync timing constants, so generator and recoverer share one source: H_DISPLAY, H_MAX, V_DISPLAY, V_MAX, sync start values.
- H_EDGE_POS and V_EDGE_POS are derived in the package as sync_start+2 and v_sync_start.
- The package also holds the state enum {SEARCH, LOCKED}.
- One sub-module, sync_edge_detect: 1-bit registered rise detector with reset-high preload, instantiated twice.

Test Plan:
- Drive from hvsync_generator with defaults.
  - Expected: locked rises after the 4th matching hsync and the first vsync.
  - Expected: from then on hpos/vpos equal the generator's every cycle.
  - Expected: line_len=309, frame_lines=262.
- Reset asserted with hsync_in=1, then released.
  - Expected: no hrise; hpos counts 0,1,2…
  - Expected: locked=0, line_len=0.
- Lock, then stall hsync_in low for 2 line periods.
  - Expected: locked drops on the 2nd miss.
  - Expected: hpos free-runs 0..308 throughout.
- Lock, then inject one hsync 10 clocks early.
  - Expected: hpos reloads to 266, mcnt=1.
  - Expected: following on-time edges still miss, because of the phase shift, so locked falls after the next miss.
- Lock, then inject vsync on vpos=100.
  - Expected: immediate SEARCH, vpos jumps to 254.
  - Expected: relock after 4 lines plus the next matching vsync.
- Apply hrise and vrise in the same cycle.
  - Expected: hpos=266 and vpos=254 on the next cycle.
